// File: rtl/io_pkg.sv
// Shared constants and helpers for the I/O port bank.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents: default widths/depths and the flattened-bus slice helper.
package io_pkg;

  localparam int IO_DATA_W      = 16;
  localparam int IO_NUM_PORTS   = 8;
  localparam int IO_SYNC_STAGES = 2;

  // Bit offset of port n inside a flattened NUM_PORTS*DATA_W bus.
  function automatic int io_port_slice(input int n, input int data_w = IO_DATA_W);
    return n * data_w;
  endfunction

endpackage

// File: rtl/io_port_bank_if.sv
// Processor-side bus of the port bank: read from Operand Decode, write from Write Back.
// Latency: ReadInputs is combinational; writes land on the next edge.
// Backpressure: none; every Eip/Lop is accepted in the cycle it is presented.
//
// master: pipeline side (drives enables, selects, write data; receives read data)
// slave : port bank side
interface io_port_bank_if
  import io_pkg::*;
#(
  parameter int DATA_W    = IO_DATA_W,
  parameter int NUM_PORTS = IO_NUM_PORTS,
  parameter int SEL_W     = $clog2(NUM_PORTS)
);

  logic              Eip;
  logic              Lop;
  logic [SEL_W-1:0]  ioSel_RD;
  logic [SEL_W-1:0]  ioSel_WB;
  logic [DATA_W-1:0] WriteOutputs;
  logic [DATA_W-1:0] ReadInputs;

  modport master (
    output Eip, Lop, ioSel_RD, ioSel_WB, WriteOutputs,
    input  ReadInputs
  );

  modport slave (
    input  Eip, Lop, ioSel_RD, ioSel_WB, WriteOutputs,
    output ReadInputs
  );

endinterface

// File: rtl/io_in_sync.sv
// Synchronises one asynchronous producer strobe and emits a one-cycle rising-edge pulse.
// Latency: strobe high at edge k -> rise high after edge k+SYNC_STAGES-1.
// Backpressure: none; pulses narrower than SYNC_STAGES+1 cycles may be lost.
//
// Ports: Clk, Rst (sync, active-high), stb_async (async strobe in), rise (pulse out).
module io_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Rst,
  input  logic stb_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset clears the chain and the previous-value flop, so a strobe still
  // held high across reset is seen as one fresh rising edge afterwards.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], stb_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/io_port_bank.sv
// Bank of NUM_PORTS output registers and strobe-captured input registers with pending/overrun flags.
// Latency: writes/strobes 1 edge after Lop; capture SYNC_STAGES edges after strobe; reads combinational.
// Backpressure: none; a capture on an unread port overwrites the data and raises the overrun flag.
//
// Ports: Clk, Rst (sync, active-high); bus (Eip/Lop/selects/data, slave side);
//        ioOut/ioOutStb (output ports + write pulses); ioIn/ioInStb (input ports + async strobes);
//        ioPend/ioOvr (sticky per-port flags, cleared by a read of that port).
module io_port_bank
  import io_pkg::*;
#(
  parameter int DATA_W      = IO_DATA_W,
  parameter int NUM_PORTS   = IO_NUM_PORTS,
  parameter int SEL_W       = $clog2(NUM_PORTS),
  parameter int SYNC_STAGES = IO_SYNC_STAGES
) (
  input  logic                        Clk,
  input  logic                        Rst,
  io_port_bank_if.slave               bus,
  output logic [NUM_PORTS*DATA_W-1:0] ioOut,
  output logic [NUM_PORTS-1:0]        ioOutStb,
  input  logic [NUM_PORTS*DATA_W-1:0] ioIn,
  input  logic [NUM_PORTS-1:0]        ioInStb,
  output logic [NUM_PORTS-1:0]        ioPend,
  output logic [NUM_PORTS-1:0]        ioOvr
);

  logic [NUM_PORTS-1:0] rise;
  logic [DATA_W-1:0]    cap_reg [NUM_PORTS];

  for (genvar n = 0; n < NUM_PORTS; n++) begin : g_port
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] cap_q;
    logic              stb_q;
    logic              pend_q;
    logic              ovr_q;
    logic              wr_sel;
    logic              rd_clr;

    io_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .Clk       (Clk),
      .Rst       (Rst),
      .stb_async (ioInStb[n]),
      .rise      (rise[n])
    );

    assign wr_sel = bus.Lop && (bus.ioSel_WB == SEL_W'(n));
    assign rd_clr = bus.Eip && (bus.ioSel_RD == SEL_W'(n));

    always_ff @(posedge Clk) begin
      if (Rst) begin
        out_q  <= '0;
        cap_q  <= '0;
        stb_q  <= 1'b0;
        pend_q <= 1'b0;
        ovr_q  <= 1'b0;
      end else begin
        if (wr_sel) out_q <= bus.WriteOutputs;
        // Strobe pulses on every write, even when the value is unchanged.
        stb_q <= wr_sel;

        // Producer holds ioIn stable while its strobe is high, so the
        // unsynchronised data is safe to sample on the synchronised edge.
        if (rise[n]) cap_q <= ioIn[io_port_slice(n, DATA_W) +: DATA_W];

        // Capture beats a same-edge read-clear for pend; the read consumed
        // the old data, so overrun is cleared rather than raised.
        if (rise[n])     pend_q <= 1'b1;
        else if (rd_clr) pend_q <= 1'b0;

        if (rd_clr)                 ovr_q <= 1'b0;
        else if (rise[n] && pend_q) ovr_q <= 1'b1;
      end
    end

    assign ioOut[io_port_slice(n, DATA_W) +: DATA_W] = out_q;
    assign ioOutStb[n] = stb_q;
    assign ioPend[n]   = pend_q;
    assign ioOvr[n]    = ovr_q;
    assign cap_reg[n]  = cap_q;
  end

  // Read path is forced to zero when idle; no tristate on the decode bus.
  always_comb begin
    bus.ReadInputs = '0;
    if (bus.Eip && (int'(bus.ioSel_RD) < NUM_PORTS)) begin
      bus.ReadInputs = cap_reg[bus.ioSel_RD];
    end
  end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank: default build plus a 4-port/8-bit/3-stage build.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_io_port_bank;

  logic Clk = 1'b0;
  logic Rst = 1'b1;

  always #5 Clk = ~Clk;

  // Default-parameter instance (A)
  io_port_bank_if #(.DATA_W(16), .NUM_PORTS(8)) ifa ();
  logic [127:0] ioInA  = '0;
  logic [7:0]   stbA   = '0;
  logic [127:0] ioOutA;
  logic [7:0]   ioOutStbA, pendA, ovrA;

  io_port_bank #(.DATA_W(16), .NUM_PORTS(8), .SYNC_STAGES(2)) dut_a (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (ifa),
    .ioOut    (ioOutA),
    .ioOutStb (ioOutStbA),
    .ioIn     (ioInA),
    .ioInStb  (stbA),
    .ioPend   (pendA),
    .ioOvr    (ovrA)
  );

  // Reparametrised instance (B)
  io_port_bank_if #(.DATA_W(8), .NUM_PORTS(4)) ifb ();
  logic [31:0] ioInB = '0;
  logic [3:0]  stbB  = '0;
  logic [31:0] ioOutB;
  logic [3:0]  ioOutStbB, pendB, ovrB;

  io_port_bank #(.DATA_W(8), .NUM_PORTS(4), .SYNC_STAGES(3)) dut_b (
    .Clk      (Clk),
    .Rst      (Rst),
    .bus      (ifb),
    .ioOut    (ioOutB),
    .ioOutStb (ioOutStbB),
    .ioIn     (ioInB),
    .ioInStb  (stbB),
    .ioPend   (pendB),
    .ioOvr    (ovrB)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.Eip = 0; ifa.Lop = 0; ifa.ioSel_RD = '0; ifa.ioSel_WB = '0; ifa.WriteOutputs = '0;
    ifb.Eip = 0; ifb.Lop = 0; ifb.ioSel_RD = '0; ifb.ioSel_WB = '0; ifb.WriteOutputs = '0;

    // ---- Reset with all strobes held high ----
    Rst = 1; stbA = '1; stbB = '1;
    tick(); tick();
    check("rst_ioOutA",    ioOutA, 0);
    check("rst_ioOutStbA", ioOutStbA, 0);
    check("rst_pendA",     pendA, 0);
    check("rst_ovrA",      ovrA, 0);
    check("rst_readA",     ifa.ReadInputs, 0);
    check("rst_ioOutB",    ioOutB, 0);
    check("rst_pendB",     pendB, 0);
    Rst = 0;
    tick();                                  // edge k
    check("post_rst_k_pendA", pendA, 0);
    tick();                                  // edge k+1
    check("post_rst_k1_pendA", pendA, 0);
    tick();                                  // edge k+2: A captures
    check("post_rst_k2_pendA", pendA, 8'hFF);
    check("post_rst_k2_pendB", pendB, 0);
    check("post_rst_k2_ovrA",  ovrA, 0);
    tick();                                  // edge k+3: B captures
    check("post_rst_k3_pendB", pendB, 4'hF);
    check("post_rst_one_rise_ovrA", ovrA, 0);
    check("post_rst_one_rise_ovrB", ovrB, 0);
    stbA = '0; stbB = '0;

    // Drain all pending flags
    for (int p = 0; p < 8; p++) begin
      ifa.Eip = 1; ifa.ioSel_RD = 3'(p);
      ifb.Eip = 1; ifb.ioSel_RD = 2'(p);
      tick();
    end
    ifa.Eip = 0; ifb.Eip = 0;
    check("drain_pendA", pendA, 0);
    check("drain_ovrA",  ovrA, 0);
    check("drain_pendB", pendB, 0);

    // ---- Write port 5 ----
    ifa.Lop = 1; ifa.ioSel_WB = 3'd5; ifa.WriteOutputs = 16'hBEEF;
    tick();
    ifa.Lop = 0;
    check("wr_port5",     ioOutA[5*16 +: 16], 16'hBEEF);
    check("wr_stb",       ioOutStbA, 8'b0010_0000);
    check("wr_others",    ioOutA, {16'h0, 16'h0, 16'hBEEF, 80'h0});
    tick();
    check("wr_stb_1cyc",  ioOutStbA, 0);
    check("wr_port5_hold", ioOutA[5*16 +: 16], 16'hBEEF);
    ifa.Lop = 1;                             // same value again
    tick();
    ifa.Lop = 0;
    check("rewrite_stb",  ioOutStbA, 8'b0010_0000);

    // ---- Capture / read port 2 ----
    ioInA[2*16 +: 16] = 16'h1234; stbA[2] = 1;
    tick(); tick();
    check("cap2_k1_pend", pendA[2], 0);
    tick();
    check("cap2_pend",    pendA[2], 1);
    check("cap2_ovr",     ovrA[2], 0);
    tick();
    stbA[2] = 0;
    ifa.Eip = 1; ifa.ioSel_RD = 3'd2;
    #1;
    check("rd2_data",     ifa.ReadInputs, 16'h1234);
    tick();
    ifa.Eip = 0;
    check("rd2_pend_clr", pendA[2], 0);
    #1;
    check("rd_idle_zero", ifa.ReadInputs, 0);

    // ---- Overrun on port 7 ----
    ioInA[7*16 +: 16] = 16'hAAAA; stbA[7] = 1;
    repeat (4) tick();
    stbA[7] = 0;
    repeat (4) tick();
    ioInA[7*16 +: 16] = 16'h5555; stbA[7] = 1;
    repeat (4) tick();
    stbA[7] = 0;
    check("ovr7_pend", pendA[7], 1);
    check("ovr7_ovr",  ovrA[7], 1);
    ifa.Eip = 1; ifa.ioSel_RD = 3'd7;
    #1;
    check("ovr7_read", ifa.ReadInputs, 16'h5555);
    tick();
    ifa.Eip = 0;
    check("ovr7_pend_clr", pendA[7], 0);
    check("ovr7_ovr_clr",  ovrA[7], 0);

    // ---- Simultaneous read-clear and capture on port 3, plus write to port 3 ----
    ioInA[3*16 +: 16] = 16'h0001; stbA[3] = 1;
    repeat (4) tick();
    stbA[3] = 0;
    repeat (4) tick();
    check("sim3_pre_pend", pendA[3], 1);
    ioInA[3*16 +: 16] = 16'h0002; stbA[3] = 1;
    tick(); tick();                          // rise is true before the next edge
    ifa.Eip = 1; ifa.ioSel_RD = 3'd3;
    ifa.Lop = 1; ifa.ioSel_WB = 3'd3; ifa.WriteOutputs = 16'h1111;
    #1;
    check("sim3_read_old", ifa.ReadInputs, 16'h0001);
    tick();
    ifa.Eip = 0; ifa.Lop = 0;
    check("sim3_pend",   pendA[3], 1);
    check("sim3_ovr",    ovrA[3], 0);
    check("sim3_wr",     ioOutA[3*16 +: 16], 16'h1111);
    check("sim3_wr_stb", ioOutStbA, 8'b0000_1000);
    ifa.Eip = 1;
    #1;
    check("sim3_read_new", ifa.ReadInputs, 16'h0002);
    tick();
    ifa.Eip = 0; stbA[3] = 0;
    check("sim3_pend_clr", pendA[3], 0);

    // ---- Reparametrised instance ----
    ioInB[1*8 +: 8] = 8'h3C; stbB[1] = 1;
    tick(); tick(); tick();
    check("b_cap_k2_pend", pendB[1], 0);
    tick();
    check("b_cap_k3_pend", pendB[1], 1);
    stbB[1] = 0;
    ifb.Eip = 1; ifb.ioSel_RD = 2'd1;
    ifb.Lop = 1; ifb.ioSel_WB = 2'd3; ifb.WriteOutputs = 8'hA5;
    #1;
    check("b_read", ifb.ReadInputs, 8'h3C);
    tick();
    ifb.Eip = 0; ifb.Lop = 0;
    check("b_wr_top",   ioOutB[31:24], 8'hA5);
    check("b_wr_full",  ioOutB, 32'hA500_0000);
    check("b_wr_stb",   ioOutStbB, 4'b1000);
    check("b_pend_clr", pendB[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised successor to the processor's GPIB port block: `NUM_PORTS` output registers and `NUM_PORTS` strobe-qualified input capture registers, each `DATA_W` bits. It sits between the Operand Decode stage (input reads, `Eip`) and the Write Back stage (output writes, `Lop`). New relative to the previous generation:

- inputs are captured on a synchronised producer strobe rather than read live;
- each input port has a sticky pending flag and an overrun flag;
- each output write produces a one-cycle strobe;
- the read path is driven low when idle, with no tristate.

## Interface
Parameters:
- `DATA_W`, 16, port data width
- `NUM_PORTS`, 8, number of input ports and number of output ports (≥2)
- `SEL_W`, `$clog2(NUM_PORTS)`, port-select width (derived; do not override)
- `SYNC_STAGES`, 2, strobe synchroniser depth (≥2)

Ports:
- `Clk`  in  1  global clock; single clock domain
- `Rst`  in  1  reset, synchronous, active-high
- `Eip`  in  1  read-input enable (Operand Decode stage)
- `Lop`  in  1  load-output enable (Write Back stage)
- `ioSel_RD`  in  `SEL_W`  input port select for reads
- `ioSel_WB`  in  `SEL_W`  output port select for writes
- `WriteOutputs`  in  `DATA_W`  write data from Write Back
- `ReadInputs`  out  `DATA_W`  read data to Operand Decode
- `ioOut`  out  `NUM_PORTS*DATA_W`  output ports, flattened; port n occupies `[n*DATA_W +: DATA_W]`
- `ioOutStb`  out  `NUM_PORTS`  one-cycle pulse per output port when that port is written
- `ioIn`  in  `NUM_PORTS*DATA_W`  input port data, flattened like `ioOut`
- `ioInStb`  in  `NUM_PORTS`  asynchronous producer strobes, one per input port
- `ioPend`  out  `NUM_PORTS`  sticky "new data captured" flag per port
- `ioOvr`  out  `NUM_PORTS`  sticky overrun flag per port

## Operation
- **Output path.** On a clock edge with `Lop=1`:
  - `outReg[ioSel_WB]` loads `WriteOutputs`;
  - `ioOutStb[ioSel_WB]` is 1 for the following cycle; all other strobe bits are 0.
  - A rewrite of the same value still pulses the strobe.
- **Input synchroniser.** Per port, `ioInStb[n]` passes through `SYNC_STAGES` flops, then a previous-value flop. `rise[n] = sync_out & ~prev`.
- **Producer protocol.** `ioIn[n]` must be stable from strobe assertion until strobe deassertion. Data is captured directly from `ioIn` and is not synchronised.
- **Capture.** On an edge with `rise[n]=1`:
  - `capReg[n]` loads `ioIn[n]`;
  - `ioPend[n]` is set;
  - if `ioPend[n]` was already 1 and is not being cleared on this edge, `ioOvr[n]` is also set.
- **Read.** `ReadInputs = Eip ? capReg[ioSel_RD] : 0`. This is combinational, with no added latency to the decode stage.
  - On an edge with `Eip=1`, `ioPend[ioSel_RD]` and `ioOvr[ioSel_RD]` clear.
- **Simultaneous read-clear and capture on the same port:**
  - the read returns the old `capReg`;
  - the capture wins, so `ioPend` stays 1;
  - `ioOvr` is cleared (the old data was consumed).
- **Independence.** A read and a write in the same cycle, to any port combination, are independent.
- **Mid-operation reset.** Reset discards in-flight strobes: synchroniser and previous-value flops clear to 0. A strobe still high after reset therefore produces one fresh `rise` after `SYNC_STAGES` cycles.

## Timing
- **Reset values:** all `outReg`, `capReg`, `ioPend`, `ioOvr`, `ioOutStb`, synchroniser and previous-value flops are 0. `ReadInputs` is 0 while `Eip=0`.
- **Write latency:** `Lop` sampled at edge k → `ioOut` port and `ioOutStb` updated after edge k.
- **Capture latency:** `ioInStb` high at edge k → `rise` true after edge k+`SYNC_STAGES`−1 → `capReg`/`ioPend` updated after edge k+`SYNC_STAGES`.
- **Minimum strobe widths:** high pulse ≥ `SYNC_STAGES`+1 cycles; low gap ≥ `SYNC_STAGES`+1 cycles. Shorter pulses may be lost.
- **Read data** is valid in the same cycle as `Eip`. The flag clear is visible after that edge.

## Structure
- **Package `io_pkg`:**
  - default constants `IO_DATA_W=16`, `IO_NUM_PORTS=8`, `IO_SYNC_STAGES=2`;
  - function `io_port_slice(n)` returning the flattened bit offset.
- **Sub-module `io_in_sync`**, instantiated `NUM_PORTS` times via generate:
  - synchroniser chain plus edge detect;
  - ports `Clk`, `Rst`, `stb_async`, `rise`.
- **Top-level** holds the `outReg`/`capReg` arrays, the flags and the read mux.

## Test plan
- **Reset:** assert `Rst` for 2 cycles with `ioInStb` all high → all outputs 0. Exactly one `rise` per port follows `SYNC_STAGES` cycles after release.
- **Write:** `Lop=1`, `ioSel_WB=5`, `WriteOutputs=16'hBEEF` → port 5 = `BEEF` and `ioOutStb=8'b0010_0000` for exactly 1 cycle; other ports hold 0.
- **Capture/read:** port 2 `ioIn=16'h1234`, strobe high 4 cycles → `ioPend[2]=1` after 2 edges. `Eip=1`, `ioSel_RD=2` → `ReadInputs=1234` in the same cycle; `ioPend[2]=0` after the edge. `Eip=0` → `ReadInputs=0`.
- **Overrun:** two strobes on port 7 (data `AAAA`, then `5555`) with no read → `ioPend[7]=1`, `ioOvr[7]=1`, read returns `5555`, then both flags clear.
- **Simultaneous read and capture:** `rise` on port 3 coincides with `Eip` read of port 3 (old value `0001`, new value `0002`) → read returns `0001`; after the edge `capReg=0002`, `ioPend[3]=1`, `ioOvr[3]=0`.
- **Parametrisation:** `NUM_PORTS=4`, `DATA_W=8`, `SYNC_STAGES=3` → capture occurs 3 edges after strobe; write to port 3 with `8'hA5` appears on `ioOut[31:24]`.
